elevator_call_panel: RTL and testbench
======================================

Name: elevator_call_panel

Overview:
Front end for the elevator controller's button interface. Debounces raw car buttons, hall buttons and door buttons, and latches each press as a held request. Drives the controller's request inputs and the button lamps, and clears each request when the controller reports the car serving that floor with the door open. It closes the loop on the controller's floor, up, down and door status outputs.

Parameters:
DEBOUNCE_CYCLES, 4, number of consecutive sampled edges a raw input must hold a new level before it is accepted; legal range 1..15.
CNT_W, 4, debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high; clock clk
raw_car  input  4  car buttons, bit i = floor i+1 (floors 1..4)
raw_hall_up  input  3  hall up buttons, bit i = floor i+1 (floors 1..3)
raw_hall_dn  input  3  hall down buttons, bit i = floor i+2 (floors 2..4)
raw_dopen  input  1  door-open button
raw_dclose  input  1  door-close button
cur_floor  input  2  controller floor, 0..3 = floors 1..4
car_up  input  1  controller moving or committed up
car_down  input  1  controller moving or committed down
door_open  input  1  controller door open status
car_req  output  4  latched car requests, also the car lamps
hall_up_req  output  3  latched hall-up requests, also the lamps
hall_dn_req  output  3  latched hall-down requests, also the lamps
dopen_req  output  1  debounced door-open level
dclose_pulse  output  1  one-cycle pulse on a debounced door-close press
any_pending  output  1  OR of all car_req, hall_up_req and hall_dn_req

Behaviour:
- Reset: all outputs are 0, all debounce counters are 0, all debounced levels are 0, all latches are cleared. Reset overrides everything in that cycle.
- Debounce, per input (12 independent instances):
  - The counter increments on each edge where raw differs from the debounced level.
  - The counter clears to 0 on any edge where raw equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES, the level flips and the counter clears.
  - A raw high sampled on N=DEBOUNCE_CYCLES consecutive edges raises the level after the Nth edge.
  - Glitches shorter than N edges are ignored.
- Press event: the rising edge of a debounced level, one cycle wide.
- A button held through a reset release is re-debounced from 0, so its press event fires N edges after reset drops.
- Latch rule, per request bit: set on a press event, clear on a serve, otherwise hold. The output changes in the cycle after the deciding edge.
- Serve at floor f = cur_floor, only while door_open=1:
  - car_req[f] always clears.
  - car_up=1: hall up at f clears.
  - car_down=1: hall down at f clears.
  - Both car_up and car_down 0: both hall directions at f clear.
  - car_up and car_down both 1 is illegal input; treat it as idle.
- Press and serve on the same bit in the same cycle: serve wins and the bit stays 0. The call is already satisfied by the open door.
- A press at another floor, or in the unserved direction at f, latches normally while the door is open.
- Nonexistent buttons (up at floor 4, down at floor 1) do not exist as bits. Serve logic must not index out of range at f=3 (up) or f=0 (down).
- dopen_req follows the debounced level, with no latch.
- dclose_pulse is high for exactly 1 cycle per debounced press. A held button yields no further pulses.
- any_pending is combinational from the latch outputs.
- No request is ever cleared without a serve, except by reset or the optional cancel below.

Optional Feature:
Macro CALL_CANCEL_EN.
- Defined: a press event on a car button whose car_req bit is already 1 clears that bit (toggle-cancel). The exception is f=cur_floor with door_open=1, where serve clears it anyway. Hall buttons are never cancellable.
- Undefined: a repeat press on a latched bit has no effect and the bit stays 1.

Test Plan:
1. Debounce: after reset, hold raw_car[2]=1. car_req[2] must be 0 through edges 1..3 and rise after edge 4. A 3-cycle pulse on raw_car[1] must leave car_req[1]=0.
2. Serve: latch hall_up_req[1] and hall_dn_req[0] (both at floor 2). Apply cur_floor=1, car_up=1, door_open=1. hall_up_req[1]→0 next cycle and hall_dn_req[0] stays 1. Then car_up=0, car_down=0 → hall_dn_req[0]→0.
3. Press during serve: cur_floor=3, door_open=1, raw_car[3] debounced press → car_req[3] stays 0. In the same window a raw_car[0] press → car_req[0]=1 and any_pending=1.
4. Door buttons: hold raw_dclose for 10 cycles → dclose_pulse high exactly 1 cycle, 4 edges after assertion. Hold raw_dopen → dopen_req=1 until raw has been low for 4 edges.
5. Reset mid-operation: with car_req=4'b1010 and raw_car[0] held, pulse reset. All outputs are 0 the cycle after, and car_req[0] rises 4 edges after reset release.
6. CALL_CANCEL_EN: latch car_req[1], release, press again at cur_floor=0. Defined: car_req[1]→0. Undefined: car_req[1] stays 1.

Source files
------------

// File: rtl/elevator_call_panel.sv
// Elevator call panel: debounces 12 raw buttons, latches car/hall requests and clears them on serve.
// Optional macro CALL_CANCEL_EN enables toggle-cancel of latched car requests.
module elevator_call_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] raw_car,
  input  logic [2:0] raw_hall_up,
  input  logic [2:0] raw_hall_dn,
  input  logic       raw_dopen,
  input  logic       raw_dclose,
  input  logic [1:0] cur_floor,
  input  logic       car_up,
  input  logic       car_down,
  input  logic       door_open,
  output logic [3:0] car_req,
  output logic [2:0] hall_up_req,
  output logic [2:0] hall_dn_req,
  output logic       dopen_req,
  output logic       dclose_pulse,
  output logic       any_pending
);

  localparam int NB = 12;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // bits 3:0 car, 6:4 hall up, 9:7 hall down, 10 door open, 11 door close
  logic [NB-1:0]    raw_s;
  logic [NB-1:0]    lvl_q, lvl_d, press_s;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];
  logic [3:0]       car_req_q, car_req_d;
  logic [2:0]       hall_up_q, hall_up_d;
  logic [2:0]       hall_dn_q, hall_dn_d;
  logic             dclose_q, dclose_d;
  logic             idle_s, up_srv_s, dn_srv_s;

  assign raw_s = {raw_dclose, raw_dopen, raw_hall_dn, raw_hall_up, raw_car};

  // Debounce: count edges where raw disagrees with the level; flip on the Nth
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      cnt_d[i]   = {CNT_W{1'b0}};
      lvl_d[i]   = lvl_q[i];
      press_s[i] = 1'b0;
      if (raw_s[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          lvl_d[i]   = raw_s[i];
          press_s[i] = raw_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = {CNT_W{1'b0}};
      end
    end
  end

  // Both direction flags high is illegal and handled as idle, so both hall calls clear
  assign idle_s   = (car_up == car_down);
  assign up_srv_s = door_open & (car_up | idle_s);
  assign dn_srv_s = door_open & (car_down | idle_s);

  // Request latches: serve beats press, press sets, otherwise hold
  always_comb begin
    car_req_d = car_req_q;
    hall_up_d = hall_up_q;
    hall_dn_d = hall_dn_q;
    dclose_d  = press_s[11];
    for (int i = 0; i < 4; i++) begin
      if (door_open && (cur_floor == 2'(i))) begin
        car_req_d[i] = 1'b0;
      end else if (press_s[i]) begin
`ifdef CALL_CANCEL_EN
        car_req_d[i] = ~car_req_q[i];
`else
        car_req_d[i] = 1'b1;
`endif
      end else begin
        car_req_d[i] = car_req_q[i];
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (up_srv_s && (cur_floor == 2'(i))) begin
        hall_up_d[i] = 1'b0;
      end else if (press_s[4+i]) begin
        hall_up_d[i] = 1'b1;
      end else begin
        hall_up_d[i] = hall_up_q[i];
      end
      // hall-down bit i belongs to floor i+2, i.e. cur_floor value i+1
      if (dn_srv_s && (cur_floor == 2'(i + 1))) begin
        hall_dn_d[i] = 1'b0;
      end else if (press_s[7+i]) begin
        hall_dn_d[i] = 1'b1;
      end else begin
        hall_dn_d[i] = hall_dn_q[i];
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
      lvl_q     <= {NB{1'b0}};
      car_req_q <= 4'b0000;
      hall_up_q <= 3'b000;
      hall_dn_q <= 3'b000;
      dclose_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      lvl_q     <= lvl_d;
      car_req_q <= car_req_d;
      hall_up_q <= hall_up_d;
      hall_dn_q <= hall_dn_d;
      dclose_q  <= dclose_d;
    end
  end

  assign car_req      = car_req_q;
  assign hall_up_req  = hall_up_q;
  assign hall_dn_req  = hall_dn_q;
  assign dopen_req    = lvl_q[10];
  assign dclose_pulse = dclose_q;
  assign any_pending  = (|car_req_q) | (|hall_up_q) | (|hall_dn_q);

endmodule

// File: tb/tb_elevator_call_panel.sv
// Self-checking bench for elevator_call_panel: directed plan scenarios plus random stimulus
// compared every cycle against a floor-indexed behavioural model.
module tb_elevator_call_panel;

  localparam int N = 4;
`ifdef CALL_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] raw_car;
  logic [2:0] raw_hall_up, raw_hall_dn;
  logic       raw_dopen, raw_dclose;
  logic [1:0] cur_floor;
  logic       car_up, car_down, door_open;
  logic [3:0] car_req;
  logic [2:0] hall_up_req, hall_dn_req;
  logic       dopen_req, dclose_pulse, any_pending;

  int n_cmp = 0;
  int n_bad = 0;

  elevator_call_panel #(.DEBOUNCE_CYCLES(N), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .raw_car(raw_car), .raw_hall_up(raw_hall_up), .raw_hall_dn(raw_hall_dn),
    .raw_dopen(raw_dopen), .raw_dclose(raw_dclose),
    .cur_floor(cur_floor), .car_up(car_up), .car_down(car_down), .door_open(door_open),
    .car_req(car_req), .hall_up_req(hall_up_req), .hall_dn_req(hall_dn_req),
    .dopen_req(dopen_req), .dclose_pulse(dclose_pulse), .any_pending(any_pending)
  );

  always #5 clk = ~clk;

  // Model: per-button run length and debounced level; requests indexed by floor number 1..4
  int run_len [12];
  bit deb     [12];
  bit m_car   [1:4];
  bit m_hup   [1:4];
  bit m_hdn   [1:4];
  bit m_dcl;

  wire [11:0] raw_all = {raw_dclose, raw_dopen, raw_hall_dn, raw_hall_up, raw_car};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pr [12];
    int f;
    bit going_up, going_dn;
    if (reset) begin
      for (int b = 0; b < 12; b++) begin
        run_len[b] = 0;
        deb[b] = 1'b0;
      end
      for (int fl = 1; fl <= 4; fl++) begin
        m_car[fl] = 1'b0;
        m_hup[fl] = 1'b0;
        m_hdn[fl] = 1'b0;
      end
      m_dcl = 1'b0;
    end else begin
      for (int b = 0; b < 12; b++) begin
        pr[b] = 1'b0;
        if (raw_all[b] != deb[b]) begin
          run_len[b]++;
          if (run_len[b] == N) begin
            deb[b] = ~deb[b];
            run_len[b] = 0;
            pr[b] = deb[b];
          end
        end else begin
          run_len[b] = 0;
        end
      end
      f = int'(cur_floor) + 1;
      going_up = car_up && !car_down;
      going_dn = car_down && !car_up;
      for (int fl = 1; fl <= 4; fl++) begin
        if (door_open && f == fl) m_car[fl] = 1'b0;
        else if (pr[fl-1]) m_car[fl] = CANCEL ? ~m_car[fl] : 1'b1;
      end
      for (int fl = 1; fl <= 3; fl++) begin
        if (door_open && f == fl && !going_dn) m_hup[fl] = 1'b0;
        else if (pr[3+fl]) m_hup[fl] = 1'b1;
      end
      for (int fl = 2; fl <= 4; fl++) begin
        if (door_open && f == fl && !going_up) m_hdn[fl] = 1'b0;
        else if (pr[5+fl]) m_hdn[fl] = 1'b1;
      end
      m_dcl = pr[11];
    end
  endtask

  task automatic tick();
    logic [3:0] e_car;
    logic [2:0] e_hu, e_hd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    e_car = {m_car[4], m_car[3], m_car[2], m_car[1]};
    e_hu  = {m_hup[3], m_hup[2], m_hup[1]};
    e_hd  = {m_hdn[4], m_hdn[3], m_hdn[2]};
    check_eq("car_req",      32'(car_req),      32'(e_car));
    check_eq("hall_up_req",  32'(hall_up_req),  32'(e_hu));
    check_eq("hall_dn_req",  32'(hall_dn_req),  32'(e_hd));
    check_eq("dopen_req",    32'(dopen_req),    32'(deb[10]));
    check_eq("dclose_pulse", 32'(dclose_pulse), 32'(m_dcl));
    check_eq("any_pending",  32'(any_pending),  32'((|e_car) | (|e_hu) | (|e_hd)));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int pcnt, pat;
    reset = 1'b1;
    raw_car = 4'b0000; raw_hall_up = 3'b000; raw_hall_dn = 3'b000;
    raw_dopen = 1'b0; raw_dclose = 1'b0;
    cur_floor = 2'd0; car_up = 1'b0; car_down = 1'b0; door_open = 1'b0;
    ticks(2);
    check_eq("rst_car", 32'(car_req), 32'h0);
    check_eq("rst_any", 32'(any_pending), 32'h0);
    reset = 1'b0;

    // 1: debounce latency and glitch rejection
    raw_car = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("t1_hold", 32'(car_req[2]), 0);
    end
    tick();
    check_eq("t1_rise", 32'(car_req[2]), 1);
    raw_car = 4'b0110;
    ticks(3);
    raw_car = 4'b0100;
    ticks(2);
    check_eq("t1_glitch", 32'(car_req[1]), 0);

    // 2: directional hall serve at floor 2
    raw_car = 4'b0000; raw_hall_up = 3'b010; raw_hall_dn = 3'b001;
    ticks(4);
    raw_hall_up = 3'b000; raw_hall_dn = 3'b000;
    ticks(4);
    check_eq("t2_hu_set", 32'(hall_up_req[1]), 1);
    check_eq("t2_hd_set", 32'(hall_dn_req[0]), 1);
    cur_floor = 2'd1; car_up = 1'b1; door_open = 1'b1;
    tick();
    check_eq("t2_hu_srv", 32'(hall_up_req[1]), 0);
    check_eq("t2_hd_keep", 32'(hall_dn_req[0]), 1);
    car_up = 1'b0;
    tick();
    check_eq("t2_hd_srv", 32'(hall_dn_req[0]), 0);

    // 3: press at the served floor is absorbed, press elsewhere latches
    cur_floor = 2'd3;
    raw_car = 4'b1001;
    ticks(4);
    check_eq("t3_served", 32'(car_req[3]), 0);
    check_eq("t3_other", 32'(car_req[0]), 1);
    check_eq("t3_any", 32'(any_pending), 1);
    raw_car = 4'b0000;
    ticks(4);
    door_open = 1'b0;

    // 4: door buttons
    raw_dclose = 1'b1;
    pcnt = 0; pat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (dclose_pulse) begin pcnt++; pat = k; end
    end
    check_eq("t4_pulses", 32'(pcnt), 1);
    check_eq("t4_pulse_at", 32'(pat), 4);
    raw_dclose = 1'b0;
    raw_dopen = 1'b1;
    ticks(4);
    check_eq("t4_dopen_hi", 32'(dopen_req), 1);
    raw_dopen = 1'b0;
    ticks(3);
    check_eq("t4_dopen_hold", 32'(dopen_req), 1);
    tick();
    check_eq("t4_dopen_lo", 32'(dopen_req), 0);

    // 5: reset mid-operation with a held button
    reset = 1'b1; tick(); reset = 1'b0;
    raw_car = 4'b1010;
    ticks(4);
    raw_car = 4'b0001;
    ticks(2);
    check_eq("t5_pre", 32'(car_req), 32'hA);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t5_car0", 32'(car_req), 0);
    check_eq("t5_hall", 32'({hall_up_req, hall_dn_req}), 0);
    check_eq("t5_door", 32'({dopen_req, dclose_pulse}), 0);
    check_eq("t5_any", 32'(any_pending), 0);
    ticks(3);
    check_eq("t5_wait", 32'(car_req[0]), 0);
    tick();
    check_eq("t5_rise", 32'(car_req[0]), 1);

    // 6: repeat press on a latched car request
    raw_car = 4'b0000; cur_floor = 2'd0; door_open = 1'b0;
    ticks(4);
    raw_car = 4'b0010;
    ticks(4);
    check_eq("t6_set", 32'(car_req[1]), 1);
    raw_car = 4'b0000;
    ticks(5);
    raw_car = 4'b0010;
    ticks(4);
    check_eq("t6_cancel", 32'(car_req[1]), CANCEL ? 0 : 1);
    raw_car = 4'b0000;
    ticks(4);

    // Random phase: slow-toggling raw buttons produce both glitches and real presses
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(9, 0) == 0) raw_car[i] = ~raw_car[i];
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(11, 0) == 0) raw_hall_up[i] = ~raw_hall_up[i];
        if ($urandom_range(11, 0) == 0) raw_hall_dn[i] = ~raw_hall_dn[i];
      end
      if ($urandom_range(7, 0) == 0) raw_dopen = ~raw_dopen;
      if ($urandom_range(7, 0) == 0) raw_dclose = ~raw_dclose;
      if ($urandom_range(9, 0) == 0) cur_floor = 2'($urandom_range(3, 0));
      if ($urandom_range(7, 0) == 0) {car_up, car_down} = 2'($urandom_range(3, 0));
      if ($urandom_range(5, 0) == 0) door_open = ~door_open;
      reset = ($urandom_range(399, 0) == 0);
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
